// File: rtl/port_pkg.sv
// Shared state encodings and frame constants for the port serial link.
package port_pkg;

   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned FRAME_BITS = DATA_BITS + 2;

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/port_rx.sv
// Serial-to-parallel receiver; samples mid-bit and drops frames with a bad stop bit.
module port_rx
   import port_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_rx,
   output logic       o_rec_complete,
   output logic [7:0] o_dout
);

   localparam int unsigned     CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned     Half    = CLKS_PER_BIT / 2;
   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'((Half > 0) ? Half - 1 : 0);
   localparam logic [2:0]      BitLast = 3'(DATA_BITS - 1);

   rx_state_e       r_state, w_state_nxt;
   logic [CntW-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]      r_bit, w_bit_nxt;
   logic [7:0]      r_shift, w_shift_nxt;
   logic [7:0]      r_dout, w_dout_nxt;
   logic            r_done, w_done_nxt;
   logic            w_bit_end;

   assign w_bit_end = (r_cnt == CntLast);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_dout_nxt  = r_dout;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         RxIdle: begin
            if (!i_rx) begin
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
               // With one clock per bit the mid-point is the edge that saw the start bit.
               w_state_nxt = (Half == 0) ? RxData : RxStart;
            end
         end
         RxStart: begin
            if (r_cnt == CntHalf) begin
               w_cnt_nxt   = '0;
               w_state_nxt = i_rx ? RxIdle : RxData;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         RxData: begin
            w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
            if (w_bit_end) begin
               w_shift_nxt = {i_rx, r_shift[7:1]};
               if (r_bit == BitLast) begin
                  w_state_nxt = RxStop;
               end else begin
                  w_bit_nxt = r_bit + 1'b1;
               end
            end
         end
         RxStop: begin
            w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
            if (w_bit_end) begin
               w_state_nxt = RxIdle;
               if (i_rx) begin
                  w_dout_nxt = r_shift;
                  w_done_nxt = 1'b1;
               end
            end
         end
         default: w_state_nxt = RxIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= RxIdle;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_dout  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_dout  <= w_dout_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign o_rec_complete = r_done;
   assign o_dout         = r_dout;

endmodule

// File: rtl/port_tx.sv
// Parallel-to-serial transmitter: start bit, 8 data bits LSB first, stop bit.
module port_tx
   import port_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_tr_start,
   input  logic [7:0] i_din,
   output logic       o_tr_free,
   output logic       o_tx
);

   localparam int unsigned     CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]      BitLast = 3'(DATA_BITS - 1);

   tx_state_e       r_state, w_state_nxt;
   logic [CntW-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]      r_bit, w_bit_nxt;
   logic [7:0]      r_shift, w_shift_nxt;
   logic            r_tx, w_tx_nxt;
   logic            r_free, w_free_nxt;
   logic            w_bit_end;

   assign w_bit_end = (r_cnt == CntLast);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_tx_nxt    = r_tx;
      w_free_nxt  = r_free;
      if (r_state != TxIdle) begin
         w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
      end
      unique case (r_state)
         TxIdle: begin
            if (i_tr_start) begin
               w_state_nxt = TxStart;
               w_shift_nxt = i_din;
               w_tx_nxt    = 1'b0;
               w_free_nxt  = 1'b0;
               w_cnt_nxt   = '0;
            end
         end
         TxStart: begin
            if (w_bit_end) begin
               w_state_nxt = TxData;
               w_tx_nxt    = r_shift[0];
               w_shift_nxt = r_shift >> 1;
               w_bit_nxt   = '0;
            end
         end
         TxData: begin
            if (w_bit_end) begin
               if (r_bit == BitLast) begin
                  w_state_nxt = TxStop;
                  w_tx_nxt    = 1'b1;
               end else begin
                  w_tx_nxt    = r_shift[0];
                  w_shift_nxt = r_shift >> 1;
                  w_bit_nxt   = r_bit + 1'b1;
               end
            end
         end
         TxStop: begin
            if (w_bit_end) begin
               w_state_nxt = TxIdle;
               w_free_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = TxIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= TxIdle;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_free  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
         r_free  <= w_free_nxt;
      end
   end

   assign o_tx      = r_tx;
   assign o_tr_free = r_free;

endmodule

// File: rtl/port.sv
// Full-duplex serial port: independent transmitter and receiver on one clock.
module port
   import port_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tr_start,
   input  logic [7:0] din,
   output logic       tr_free,
   output logic       tx,
   input  logic       rx,
   output logic       rec_complete,
   output logic [7:0] dout
);

   port_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_tr_start(tr_start),
      .i_din     (din),
      .o_tr_free (tr_free),
      .o_tx      (tx)
   );

   port_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_rx          (rx),
      .o_rec_complete(rec_complete),
      .o_dout        (dout)
   );

endmodule

// File: tb/tb_port.sv
// Two cross-wired port instances; received bytes are checked against a scoreboard.
module tb_port;
   import port_pkg::*;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       tr_start1, tr_start2;
   logic [7:0] din1, din2;
   logic       tr_free1, tr_free2, tx1, tx2, rc1, rc2;
   logic [7:0] dout1, dout2;
   logic       ovr, tb_rx;
   logic       w_rx2;

   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb1[$];
   exp_t sb2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign w_rx2 = ovr ? tb_rx : tx1;

   port #(.CLKS_PER_BIT(1)) u_p1 (
      .clk(clk), .reset(reset), .tr_start(tr_start1), .din(din1), .tr_free(tr_free1),
      .tx(tx1), .rx(tx2), .rec_complete(rc1), .dout(dout1)
   );

   port #(.CLKS_PER_BIT(1)) u_p2 (
      .clk(clk), .reset(reset), .tr_start(tr_start2), .din(din2), .tr_free(tr_free2),
      .tx(tx2), .rx(w_rx2), .rec_complete(rc2), .dout(dout2)
   );

   // Scoreboard: each receive pulse must match the oldest expected byte and its cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rc1 === 1'b1) begin
         n_checks++;
         if (sb1.size() == 0) begin
            n_fail++;
            $display("FAIL rx1_unexpected: pulse with dout=%h, expected no byte", dout1);
         end else begin
            e = sb1.pop_front();
            if (dout1 !== e.data || cyc != e.cyc) begin
               n_fail++;
               $display("FAIL rx1_byte: got %h at cycle %0d, expected %h at cycle %0d",
                        dout1, cyc, e.data, e.cyc);
            end
         end
      end
      if (rc2 === 1'b1) begin
         n_checks++;
         if (sb2.size() == 0) begin
            n_fail++;
            $display("FAIL rx2_unexpected: pulse with dout=%h, expected no byte", dout2);
         end else begin
            e = sb2.pop_front();
            if (dout2 !== e.data || cyc != e.cyc) begin
               n_fail++;
               $display("FAIL rx2_byte: got %h at cycle %0d, expected %h at cycle %0d",
                        dout2, cyc, e.data, e.cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp1(input logic [7:0] data, input int at);
      exp_t e;
      e.data = data;
      e.cyc  = at;
      sb1.push_back(e);
   endtask

   task automatic exp2(input logic [7:0] data, input int at);
      exp_t e;
      e.data = data;
      e.cyc  = at;
      sb2.push_back(e);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((sb1.size() != 0 || sb2.size() != 0) && n < 60) begin
         tick();
         n++;
      end
      n_checks++;
      if (sb1.size() != 0 || sb2.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d/%0d frames outstanding, expected 0/0",
                  name, sb1.size(), sb2.size());
         sb1.delete();
         sb2.delete();
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      tr_start1 = 1'b0;
      tr_start2 = 1'b0;
      din1      = 8'h00;
      din2      = 8'h00;
      ovr       = 1'b0;
      tb_rx     = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if ({tr_free1, tx1, rc1, dout1, tr_free2, tx2, rc2, dout2} !==
             {1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state: cycle %0d free/tx/rc/dout = %b%b%b %h, %b%b%b %h, expected 110 00",
                     i, tr_free1, tx1, rc1, dout1, tr_free2, tx2, rc2, dout2);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_single_frame();
      logic [9:0] fr;
      tick();
      din1      = 8'h47;
      tr_start1 = 1'b1;
      fr        = {1'b1, din1, 1'b0};
      exp2(8'h47, cyc + 1 + FRAME_BITS);
      for (int k = 0; k < 10; k++) begin
         tick();
         if (k == 7) tr_start1 = 1'b0;
         n_checks++;
         if (tx1 !== fr[k] || tr_free1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_bit%0d: tx=%b free=%b, expected tx=%b free=0",
                     k, tx1, tr_free1, fr[k]);
         end
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++;
         if (tx1 !== 1'b1 || tr_free1 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle%0d: tx=%b free=%b, expected tx=1 free=1", k, tx1, tr_free1);
         end
      end
      drain("single");
   endtask

   task automatic test_overlap();
      tick();
      din1      = 8'h47;
      tr_start1 = 1'b1;
      exp2(8'h47, cyc + 1 + FRAME_BITS);
      tick();
      tr_start1 = 1'b0;
      din1      = 8'h00;
      tick();
      tick();
      din2      = 8'h81;
      tr_start2 = 1'b1;
      exp1(8'h81, cyc + 1 + FRAME_BITS);
      tick();
      tr_start2 = 1'b0;
      din2      = 8'h00;
      drain("overlap");
      n_checks++;
      if (dout1 !== 8'h81 || dout2 !== 8'h47) begin
         n_fail++;
         $display("FAIL overlap_hold: dout1=%h dout2=%h, expected 81 47", dout1, dout2);
      end
   endtask

   task automatic send_raw(input logic [7:0] data, input logic stop);
      logic [9:0] fr;
      fr = {stop, data, 1'b0};
      for (int j = 0; j < 10; j++) begin
         tb_rx = fr[j];
         tick();
      end
      tb_rx = 1'b1;
   endtask

   task automatic test_framing();
      ovr   = 1'b1;
      tb_rx = 1'b1;
      tick();
      tick();
      send_raw(8'hA5, 1'b0);
      repeat (3) tick();
      n_checks++;
      if (dout2 !== 8'h47) begin
         n_fail++;
         $display("FAIL framing_hold: dout2=%h, expected 47", dout2);
      end
      exp2(8'h3C, cyc + FRAME_BITS);
      send_raw(8'h3C, 1'b1);
      drain("framing");
      n_checks++;
      if (dout2 !== 8'h3C) begin
         n_fail++;
         $display("FAIL framing_good: dout2=%h, expected 3c", dout2);
      end
      ovr = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [9:0] fr;
      logic [7:0] b;
      logic       etx, efree;
      int         base;
      tick();
      din1      = 8'hFF;
      tr_start1 = 1'b1;
      base      = cyc + 1;
      exp2(8'hFF, base + 10);
      exp2(8'hFF, base + 21);
      exp2(8'h5A, base + 32);
      for (int f = 0; f < 3; f++) begin
         b  = (f < 2) ? 8'hFF : 8'h5A;
         fr = {1'b1, b, 1'b0};
         for (int k = 0; k < 11; k++) begin
            tick();
            if (f == 1 && k == 4) din1 = 8'h5A;
            if (f == 2 && k == 0) tr_start1 = 1'b0;
            etx   = (k == 10) ? 1'b1 : fr[k];
            efree = (k == 10);
            n_checks++;
            if (tx1 !== etx || tr_free1 !== efree) begin
               n_fail++;
               $display("FAIL b2b_f%0d_k%0d: tx=%b free=%b, expected tx=%b free=%b",
                        f, k, tx1, tr_free1, etx, efree);
            end
         end
      end
      drain("b2b");
   endtask

   task automatic test_reset_midframe();
      tick();
      din1      = 8'h99;
      tr_start1 = 1'b1;
      tick();
      tr_start1 = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      tick();
      n_checks++;
      if (tx1 !== 1'b1 || tr_free1 !== 1'b1 || rc2 !== 1'b0 || dout2 !== 8'h00) begin
         n_fail++;
         $display("FAIL midreset_state: tx1=%b free1=%b rc2=%b dout2=%h, expected 1 1 0 00",
                  tx1, tr_free1, rc2, dout2);
      end
      reset = 1'b0;
      repeat (15) tick();
      n_checks++;
      if (dout2 !== 8'h00 || tx1 !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_after: dout2=%h tx1=%b, expected 00 1", dout2, tx1);
      end
      din2      = 8'hA5;
      tr_start2 = 1'b1;
      exp1(8'hA5, cyc + 1 + FRAME_BITS);
      tick();
      tr_start2 = 1'b0;
      drain("midreset_recover");
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_overlap();
      test_framing();
      test_back_to_back();
      test_reset_midframe();
      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
